mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: MAX_D_STREAK, 4, max consecutive D grants while I_REQ is pending; TIMEOUT, 255, max BUSY cycles waiting for M_ACK.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset.
REQ-003 Ports SHALL be (name  direction  width  meaning):
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous reset, active-low.
- I_REQ  in  1  fetch request, held until I_ACK.
- I_ADDR  in  32  fetch address.
- I_ACK  out  1  one-cycle fetch completion.
- I_RDATA  out  32  fetch data.
- I_ERR  out  1  fetch timeout, valid with I_ACK.
- D_REQ  in  1  data request, held until D_ACK.
- D_WE  in  1  1 = store.
- D_ADDR  in  32  data address.
- D_WDATA  in  32  store data.
- D_SIZE  in  2  access size.
- D_SIGN  in  1  load sign control.
- D_ACK  out  1  one-cycle data completion.
- D_RDATA  out  32  load data.
- D_ERR  out  1  data timeout, valid with D_ACK.
- M_REQ  out  1  shared memory request, held until M_ACK.
- M_WE  out  1  memory write enable.
- M_ADDR  out  32  memory address.
- M_WDATA  out  32  memory write data.
- M_SIZE  out  2  memory access size.
- M_SIGN  out  1  memory sign control.
- M_ACK  in  1  memory completion pulse.
- M_RDATA  in  32  memory read data, valid with M_ACK.

Function
REQ-004 FSM states SHALL be IDLE, BUSY_I, BUSY_D; one outstanding memory transaction at a time.
REQ-005 In IDLE at a rising edge, if any unmasked request is high, the block SHALL grant it, go to BUSY_x, and register M_REQ=1 plus all M_* fields from the winner (I: M_WE=0, M_SIZE=2'b10, M_SIGN=0, M_WDATA=0).
REQ-006 Priority SHALL be D over I, except when both are requesting and d_streak==MAX_D_STREAK; then I wins.
REQ-007 d_streak SHALL increment (saturating at MAX_D_STREAK) on a D grant with I_REQ high, and clear on any I grant or on a D grant with I_REQ low.
REQ-008 M_* outputs SHALL stay constant throughout BUSY_x.
REQ-009 In BUSY_x at an edge with M_ACK=1, the block SHALL set M_REQ=0, x_ACK=1 for exactly one cycle, x_RDATA=M_RDATA, x_ERR=0, and go to IDLE.
REQ-010 x_RDATA SHALL hold its value until the next x_ACK.
REQ-011 Latency: M_REQ SHALL rise 1 cycle after the request is sampled; x_ACK SHALL rise 1 cycle after M_ACK is sampled.
REQ-012 In the IDLE cycle in which x_ACK is high, x_REQ SHALL be masked, so back-to-back transactions from the same port are spaced by at least one IDLE cycle.
REQ-013 The busy counter SHALL clear on grant and increment each BUSY cycle without M_ACK.
REQ-014 On reaching TIMEOUT, the block SHALL set x_ACK=1, x_ERR=1, x_RDATA=0, M_REQ=0, and go to IDLE.
REQ-015 M_ACK in the same edge as timeout SHALL take precedence: normal completion, ERR=0.
REQ-016 M_ACK while in IDLE SHALL be ignored.
REQ-017 I_ACK and D_ACK SHALL never be high in the same cycle.

Reset
REQ-018 While RESET=0 at an edge, the block SHALL set state=IDLE, d_streak=0, busy counter=0, and all outputs=0.
REQ-019 Reset during BUSY_x SHALL abort the transaction with no x_ACK issued; requests SHALL be re-arbitrated from IDLE after release.

Verification
REQ-020 Single fetch: I_REQ=1, I_ADDR=0x100; memory acks 2 cycles after M_REQ with 0xDEADBEEF -> M_ADDR=0x100, M_WE=0; I_ACK pulses 1 cycle with I_RDATA=0xDEADBEEF.
REQ-021 Contention: I_REQ and D_REQ rise together, D_WE=1, D_ADDR=0x2000, D_WDATA=0x55 -> D is served first with M_WE=1; I is served after the D_ACK cycle plus the IDLE cycle.
REQ-022 Starvation guard: D_REQ held with 6 back-to-back requests while I_REQ is held -> grant order D,D,D,D,I,D,D.
REQ-023 Timeout: D_REQ with M_ACK held low -> D_ACK=1, D_ERR=1, D_RDATA=0 on the 255th BUSY cycle; M_REQ=0 the same cycle.
REQ-024 Reset mid-operation: RESET=0 during BUSY_I -> next cycle all outputs 0, no I_ACK; after release with I_REQ still high, the fetch is re-issued.
REQ-025 Stray ack: M_ACK=1 pulsed in IDLE -> no x_ACK, state unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a fetch and a data requester,
// D-first with a streak guard for I, a per-transaction timeout and registered outputs.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        I_REQ,
  input  logic [31:0] I_ADDR,
  output logic        I_ACK,
  output logic [31:0] I_RDATA,
  output logic        I_ERR,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  input  logic [1:0]  D_SIZE,
  input  logic        D_SIGN,
  output logic        D_ACK,
  output logic [31:0] D_RDATA,
  output logic        D_ERR,
  output logic        M_REQ,
  output logic        M_WE,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_WDATA,
  output logic [1:0]  M_SIZE,
  output logic        M_SIGN,
  input  logic        M_ACK,
  input  logic [31:0] M_RDATA
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic m_req_q, m_req_d, m_we_q, m_we_d, m_sign_q, m_sign_d;
  logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [1:0] m_size_q, m_size_d;
  logic i_ack_q, i_ack_d, i_err_q, i_err_d, d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic idle, busy, gnt_i, gnt_d, gnt, tmo, fin;
  assign idle = state_q == IDLE;
  assign busy = ~idle;
  // any ack cycle is a dead arbitration cycle, which spaces same-port transactions
  assign gnt_i = idle & ~i_ack_q & ~d_ack_q & I_REQ & (~D_REQ | streak_q == SW'(MAX_D_STREAK));
  assign gnt_d = idle & ~i_ack_q & ~d_ack_q & D_REQ & ~gnt_i;
  assign gnt = gnt_i | gnt_d;
  assign tmo = busy & ~M_ACK & (cnt_q == CW'(TIMEOUT - 1));
  assign fin = (busy & M_ACK) | tmo;
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      streak_q  <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_size_q  <= '0;
      m_sign_q  <= 1'b0;
      i_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      streak_q  <= streak_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_size_q  <= m_size_d;
      m_sign_q  <= m_sign_d;
      i_ack_q   <= i_ack_d;
      i_err_q   <= i_err_d;
      i_rdata_q <= i_rdata_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  always_comb begin
    state_d = gnt_i ? BUSY_I : gnt_d ? BUSY_D : fin ? IDLE : state_q;
  end
  always_comb begin
    m_req_d   = gnt ? 1'b1 : fin ? 1'b0 : m_req_q;
    m_we_d    = gnt ? gnt_d & D_WE : m_we_q;
    m_addr_d  = gnt ? (gnt_d ? D_ADDR : I_ADDR) : m_addr_q;
    m_wdata_d = gnt ? (gnt_d ? D_WDATA : 32'h0) : m_wdata_q;
    m_size_d  = gnt ? (gnt_d ? D_SIZE : 2'b10) : m_size_q;
    m_sign_d  = gnt ? gnt_d & D_SIGN : m_sign_q;
    i_ack_d   = fin & (state_q == BUSY_I);
    d_ack_d   = fin & (state_q == BUSY_D);
    i_err_d   = i_ack_d & tmo;
    d_err_d   = d_ack_d & tmo;
    i_rdata_d = i_ack_d ? (tmo ? 32'h0 : M_RDATA) : i_rdata_q;
    d_rdata_d = d_ack_d ? (tmo ? 32'h0 : M_RDATA) : d_rdata_q;
    cnt_d     = gnt ? '0 : (busy & ~M_ACK) ? cnt_q + 1'b1 : cnt_q;
    streak_d  = gnt_i ? '0 : !gnt_d ? streak_q : !I_REQ ? '0 :
                (streak_q == SW'(MAX_D_STREAK)) ? streak_q : streak_q + 1'b1;
  end
  assign M_REQ   = m_req_q;
  assign M_WE    = m_we_q;
  assign M_ADDR  = m_addr_q;
  assign M_WDATA = m_wdata_q;
  assign M_SIZE  = m_size_q;
  assign M_SIGN  = m_sign_q;
  assign I_ACK   = i_ack_q;
  assign I_ERR   = i_err_q;
  assign I_RDATA = i_rdata_q;
  assign D_ACK   = d_ack_q;
  assign D_ERR   = d_err_q;
  assign D_RDATA = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
  logic        CLK = 1'b0, RESET = 1'b0;
  logic        I_REQ = 1'b0, D_REQ = 1'b0, D_WE = 1'b0, D_SIGN = 1'b0, M_ACK = 1'b0;
  logic [31:0] I_ADDR = '0, D_ADDR = '0, D_WDATA = '0, M_RDATA = '0;
  logic [1:0]  D_SIZE = '0;
  logic        I_ACK, I_ERR, D_ACK, D_ERR, M_REQ, M_WE, M_SIGN;
  logic [31:0] I_RDATA, D_RDATA, M_ADDR, M_WDATA;
  logic [1:0]  M_SIZE;
  int total = 0, bad = 0;

  mem_port_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_ACK(I_ACK), .I_RDATA(I_RDATA), .I_ERR(I_ERR),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_SIZE(D_SIZE),
    .D_SIGN(D_SIGN), .D_ACK(D_ACK), .D_RDATA(D_RDATA), .D_ERR(D_ERR),
    .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_SIZE(M_SIZE),
    .M_SIGN(M_SIGN), .M_ACK(M_ACK), .M_RDATA(M_RDATA)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // waits for M_REQ, checks grant latency and address, holds the memory for lat cycles, then acks
  task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] data,
                       input int exp_lat, input int lat);
    int n = 0;
    while (!M_REQ && n < 8) begin
      tick;
      n++;
    end
    chk({tag, " lat"}, n, exp_lat);
    chk({tag, " addr"}, M_ADDR, addr);
    repeat (lat) tick;
    chk({tag, " hold"}, {M_REQ, M_ADDR[30:0]}, {1'b1, addr[30:0]});
    M_ACK = 1'b1;
    M_RDATA = data;
    tick;
    M_ACK = 1'b0;
    M_RDATA = '0;
  endtask

  initial begin
    int cnt;
    tick;
    tick;
    chk("rst out", {M_REQ, M_WE, M_SIGN, I_ACK, I_ERR, D_ACK, D_ERR}, 0);
    chk("rst data", M_ADDR | M_WDATA | I_RDATA | D_RDATA | 32'(M_SIZE), 0);
    RESET = 1'b1;
    tick;
    // single fetch
    I_REQ = 1'b1;
    I_ADDR = 32'h100;
    serve("fetch", 32'h100, 32'hDEADBEEF, 1, 1);
    chk("fetch ack", {I_ACK, D_ACK, I_ERR, M_REQ}, 4'b1000);
    chk("fetch rdata", I_RDATA, 32'hDEADBEEF);
    I_REQ = 1'b0;
    tick;
    chk("fetch pulse", {I_ACK, I_RDATA}, {1'b0, 32'hDEADBEEF});
    // stray ack in idle
    M_ACK = 1'b1;
    M_RDATA = 32'h1234;
    tick;
    M_ACK = 1'b0;
    chk("stray", {I_ACK, D_ACK, M_REQ}, 0);
    chk("stray rdata", I_RDATA, 32'hDEADBEEF);
    // contention: D store first, I after the dead ack cycle
    I_REQ = 1'b1;
    D_REQ = 1'b1;
    D_WE = 1'b1;
    D_ADDR = 32'h2000;
    D_WDATA = 32'h55;
    D_SIZE = 2'b01;
    D_SIGN = 1'b1;
    serve("cont d", 32'h2000, 32'h0, 1, 0);
    chk("cont d ack", {D_ACK, I_ACK, D_ERR, M_REQ}, 4'b1000);
    D_REQ = 1'b0;
    serve("cont i", 32'h100, 32'h77, 2, 0);
    chk("cont i ack", {I_ACK, D_ACK, I_RDATA}, {2'b10, 32'h77});
    I_REQ = 1'b0;
    tick;
    // starvation guard: D held for 6 requests, I held until served
    I_REQ = 1'b1;
    D_REQ = 1'b1;
    D_WE = 1'b0;
    D_ADDR = 32'h3000;
    for (int k = 0; k < 7; k++) begin
      if (k == 4) begin
        serve($sformatf("starve%0d", k), 32'h100, 32'hA0, 2, 0);
        chk("starve i ack", {I_ACK, D_ACK, I_RDATA}, {2'b10, 32'hA0});
        chk("starve d hold", D_RDATA, 32'hD3);
        I_REQ = 1'b0;
      end else begin
        serve($sformatf("starve%0d", k), 32'h3000, 32'hD0 + k, k == 0 ? 1 : 2, 0);
        chk($sformatf("starve%0d ack", k), {D_ACK, I_ACK, D_RDATA}, {2'b10, 32'hD0 + k});
      end
    end
    D_REQ = 1'b0;
    tick;
    // timeout: M_REQ stays up for TIMEOUT cycles, then error completion
    D_REQ = 1'b1;
    D_ADDR = 32'h4000;
    tick;
    cnt = 0;
    while (M_REQ && cnt < 400) begin
      cnt++;
      tick;
    end
    chk("tmo cycles", cnt, 255);
    chk("tmo ack", {D_ACK, D_ERR, I_ACK, M_REQ}, 4'b1100);
    chk("tmo rdata", D_RDATA, 0);
    D_REQ = 1'b0;
    tick;
    chk("tmo pulse", {D_ACK, D_ERR}, 0);
    // ack on the timeout edge wins
    D_REQ = 1'b1;
    tick;
    repeat (254) tick;
    chk("race busy", M_REQ, 1);
    M_ACK = 1'b1;
    M_RDATA = 32'hCAFE;
    tick;
    M_ACK = 1'b0;
    chk("race ack", {D_ACK, D_ERR, M_REQ, D_RDATA}, {3'b100, 32'hCAFE});
    D_REQ = 1'b0;
    tick;
    // reset during BUSY_I aborts, then the fetch is re-issued
    I_REQ = 1'b1;
    I_ADDR = 32'h180;
    tick;
    chk("rst busy", M_REQ, 1);
    RESET = 1'b0;
    tick;
    chk("rst abort", {M_REQ, I_ACK, D_ACK, I_ERR}, 0);
    chk("rst abort data", M_ADDR | I_RDATA | D_RDATA, 0);
    RESET = 1'b1;
    serve("reissue", 32'h180, 32'hBEEF, 1, 1);
    chk("reissue ack", {I_ACK, D_ACK, I_RDATA}, {2'b10, 32'hBEEF});
    I_REQ = 1'b0;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
